// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: radix-2 MULT/MULTU/DIV/DIVU unit writing HI/LO (in: clk reset start op a b rd_hilo; out: busy stall done hi lo); DIV/DIVU built only with MULDIV_DIV_EN
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*W:0] p;
  logic [W-1:0] m;
  logic sq, sgn, accept;
  logic [W-1:0] am, bm;
  logic [W:0] msum;
  logic [2*W:0] mstep;
  logic [2*W-1:0] prod;
  assign sgn = ~op[0];
  assign am = (sgn & a[W-1]) ? -a : a;
  assign bm = (sgn & b[W-1]) ? -b : b;
  assign msum = p[2*W:W] + {1'b0, p[0] ? m : {W{1'b0}}};
  assign mstep = {msum, p[W-1:0]} >> 1;
  assign prod = sq ? -p[2*W-1:0] : p[2*W-1:0];
`ifdef MULDIV_DIV_EN
  logic is_div, dz, sr;
  logic [W+1:0] diff;
  logic [2*W:0] sh, dstep;
  logic [W-1:0] q, r;
  assign accept = start & (state == IDLE);
  assign sh = {p[2*W-1:0], 1'b0};
  assign diff = {1'b0, sh[2*W:W]} - {2'b0, m};
  assign dstep = diff[W+1] ? sh : {diff[W:0], p[W-2:0], 1'b1};
  assign q = sq ? -p[W-1:0] : p[W-1:0];
  assign r = sr ? -p[2*W-1:W] : p[2*W-1:W];
`else
  assign accept = start & (state == IDLE) & ~op[1];
`endif
  assign busy = state != IDLE;
  assign stall = busy & (start | rd_hilo);
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? CALC : IDLE) : state == CALC ? (cnt == '0 ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      m <= '0;
      sq <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      dz <= 1'b0;
      sr <= 1'b0;
`endif
    end else begin
      state <= state_n;
      done <= state == FIX;
      if (accept) begin
        cnt <= CW'(W - 1);
        sq <= sgn & (a[W-1] ^ b[W-1]);
`ifdef MULDIV_DIV_EN
        is_div <= op[1];
        dz <= op[1] & (b == '0);
        sr <= sgn & a[W-1];
        m <= op[1] ? bm : am;
        p <= {{(W+1){1'b0}}, op[1] ? (b == '0 ? a : am) : bm};
`else
        m <= am;
        p <= {{(W+1){1'b0}}, bm};
`endif
      end
      if (state == CALC) begin
        cnt <= cnt - 1'b1;
`ifdef MULDIV_DIV_EN
        p <= is_div ? (dz ? p : dstep) : mstep;
`else
        p <= mstep;
`endif
      end
      if (state == FIX)
`ifdef MULDIV_DIV_EN
        {hi, lo} <= is_div ? (dz ? {p[W-1:0], {W{1'b1}}} : {r, q}) : prod;
`else
        {hi, lo} <= prod;
`endif
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven and sequence checks of muldiv_sequencer at WIDTH=32
module tb_muldiv_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, rd_hilo = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic busy, stall, done;
  logic [31:0] hi, lo;
  int cmp = 0, bad = 0;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a, b, eh, el;
  } vec_t;
  vec_t v[12];
  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_hilo(rd_hilo), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_op(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] eh, input logic [31:0] el, input string nm);
    logic [31:0] ph, pl;
    int n;
    ph = hi;
    pl = lo;
    start = 1'b1;
    op = o;
    a = xa;
    b = xb;
    @(negedge clk);
    start = 1'b0;
`ifndef MULDIV_DIV_EN
    if (o[1]) begin
      chk({nm, " busy"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({nm, " done"}, 32'(done), 32'd0);
      chk({nm, " hi"}, hi, ph);
      chk({nm, " lo"}, lo, pl);
      return;
    end
`endif
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " latency"}, 32'(n), 32'd33);
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
  endtask
  initial begin
    int n;
    logic seen;
    v[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    v[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[2]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    v[3]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    v[4]  = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    v[5]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[6]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    v[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[8]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    v[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    v[10] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    v[11] = '{2'b01, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    rd_hilo = 1'b1;
    #1 chk("idle stall", 32'(stall), 32'd0);
    rd_hilo = 1'b0;
    for (int i = 0; i < 12; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].eh, v[i].el, $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
    end
    start = 1'b1;
    op = 2'b00;
    a = 32'h00000007;
    b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rd_hilo = 1'b1;
    #1 chk("busy rd_hilo stall", 32'(stall), 32'd1);
    rd_hilo = 1'b0;
    #1 chk("busy no req stall", 32'(stall), 32'd0);
    start = 1'b1;
    op = 2'b01;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    #1 chk("busy start stall", 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("ignore done", 32'(done), 32'd1);
    chk("ignore hi", hi, 32'hFFFFFFFF);
    chk("ignore lo", lo, 32'hFFFFFFF9);
    do_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, "b2b first");
    do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, "b2b second");
    start = 1'b1;
    op = 2'b01;
    a = 32'hFFFFFFFF;
    b = 32'h00000002;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd42 - 32'd42);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("abort no done", 32'(seen), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
